// File: rtl/vin_colormixer_pkg.sv
`timescale 1ns/1ps
// Shared types and constants for the video-input colour mixer.
package vin_colormixer_pkg;

  typedef enum logic [1:0] {
    MODE_MONO = 2'd0,
    MODE_CFA3 = 2'd1,
    MODE_RGBW = 2'd2,
    MODE_RSVD = 2'd3
  } mode_e;

  typedef enum logic [1:0] {
    CH_R = 2'd0,
    CH_G = 2'd1,
    CH_B = 2'd2
  } ch_e;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } rgb_t;

  localparam logic [7:0] LUMA_R = 8'd77;
  localparam logic [7:0] LUMA_G = 8'd150;
  localparam logic [7:0] LUMA_B = 8'd29;

  // Row-major 4x4 ordered-dither thresholds, index = {row[1:0], col[1:0]}.
  localparam logic [3:0] BAYER4 [16] = '{
    4'd0,  4'd8,  4'd2,  4'd10,
    4'd12, 4'd4,  4'd14, 4'd6,
    4'd3,  4'd11, 4'd1,  4'd9,
    4'd15, 4'd7,  4'd13, 4'd5
  };

  function automatic logic [1:0] mod3(input logic [2:0] v);
    case (v)
      3'd0, 3'd3, 3'd6: return 2'd0;
      3'd1, 3'd4, 3'd7: return 2'd1;
      default:          return 2'd2;
    endcase
  endfunction

endpackage

// File: rtl/vin_colormixer_mc_pixel_sel.sv
`timescale 1ns/1ps
// Per-pixel combinational selector: luma (MONO), CFA3 channel pick, or RGBW R/G/W/B pick.
module cm_pixel_sel
  import vin_colormixer_pkg::*;
#(
  parameter int unsigned K        = 0,
  parameter logic [5:0]  CFA3_SEQ = 6'b10_01_00
) (
  input  mode_e      mode,
  input  logic [1:0] x_base,
  input  logic       y_odd,
  input  rgb_t       pix,
  output logic [7:0] sel_c
);
  logic [15:0] luma_sum;
  logic [7:0]  luma;
  logic [7:0]  w_min;
  logic [1:0]  cfa_p;
  logic [1:0]  ch;
  logic        rgbw_q;
  logic [7:0]  cfa_val;
  logic [7:0]  rgbw_val;

  always_comb begin
    luma_sum = 16'(pix.r) * 16'(LUMA_R) + 16'(pix.g) * 16'(LUMA_G) + 16'(pix.b) * 16'(LUMA_B);
    luma     = 8'(luma_sum >> 8);

    w_min = (pix.r < pix.g) ? pix.r : pix.g;
    if (pix.b < w_min) w_min = pix.b;

    cfa_p = mod3(3'(x_base) + 3'(K));
    ch    = CFA3_SEQ[{cfa_p, 1'b0} +: 2];
    case (ch_e'(ch))
      CH_R:    cfa_val = pix.r;
      CH_G:    cfa_val = pix.g;
      default: cfa_val = pix.b;
    endcase

    // Even rows carry R/G, odd rows carry W/B.
    rgbw_q = x_base[0] ^ 1'(K);
    case ({y_odd, rgbw_q})
      2'b00:   rgbw_val = pix.r;
      2'b01:   rgbw_val = pix.g;
      2'b10:   rgbw_val = w_min;
      default: rgbw_val = pix.b;
    endcase

    case (mode)
      MODE_CFA3: sel_c = cfa_val;
      MODE_RGBW: sel_c = rgbw_val;
      default:   sel_c = luma;
    endcase
  end

endmodule

// File: rtl/vin_colormixer_mc.sv
`timescale 1ns/1ps
// Video-input colour mixer: PPC RGB888 pixels/clk -> PPC MONO/CFA3/RGBW samples, 2-cycle latency.
// Define VIN_COLORMIXER_DITHER_EN to add 4x4 ordered dither before depth reduction.
module vin_colormixer_mc
  import vin_colormixer_pkg::*;
#(
  parameter int unsigned PPC      = 2,
  parameter int unsigned OUT_BPP  = 8,
  parameter logic [5:0]  CFA3_SEQ = 6'b10_01_00
) (
  input  logic                   clk,
  input  logic                   rstn,
  input  logic [1:0]             cfg_mode,
  input  logic                   in_vsync,
  input  logic                   in_hsync,
  input  logic [PPC*24-1:0]      in_color,
  input  logic                   in_valid,
  output logic [PPC*OUT_BPP-1:0] out_color,
  output logic                   out_valid,
  output logic [1:0]             out_mode
);
  localparam int unsigned SHIFT = 8 - OUT_BPP;
  localparam int unsigned OW    = PPC * OUT_BPP;

  logic                vsync_q, vsync_d, hsync_q, hsync_d;
  mode_e               mode_q, mode_d;
  logic [1:0]          y_phase_q, y_phase_d, x_base_q, x_base_d;
  logic                line_active_q, line_active_d;
  logic                vs_rise, hs_rise, is_cfa3;
  logic [1:0]          y_inc, x_step;
  logic [PPC-1:0][7:0] sel_c, s1_pix_q, s1_pix_d;
  logic                s1_valid_q, s1_valid_d;
  logic [OW-1:0]       out_color_q, out_color_d;
  logic                out_valid_q, out_valid_d;
  logic [7:0]          sat;
`ifdef VIN_COLORMIXER_DITHER_EN
  logic [1:0]          row_q, row_d, col_q, col_d;
  logic [1:0]          s1_row_q, s1_row_d, s1_col_q, s1_col_d;
  logic [1:0]          pcol;
  logic [7:0]          thr;
  logic [8:0]          dsum;
`endif

  for (genvar k = 0; k < PPC; k++) begin : g_pix
    cm_pixel_sel #(
      .K       (k),
      .CFA3_SEQ(CFA3_SEQ)
    ) u_sel (
      .mode  (mode_q),
      .x_base(x_base_q),
      .y_odd (y_phase_q[0]),
      .pix   (in_color[(PPC-1-k)*24 +: 24]),
      .sel_c (sel_c[k])
    );
  end

  // Frame/line phase tracking; a sync edge takes priority over a coincident beat.
  always_comb begin
    vs_rise = in_vsync & ~vsync_q;
    hs_rise = in_hsync & ~hsync_q & ~vs_rise;
    is_cfa3 = (mode_q == MODE_CFA3);
    if (is_cfa3) y_inc = (y_phase_q == 2'd2) ? 2'd0 : y_phase_q + 2'd1;
    else         y_inc = {1'b0, ~y_phase_q[0]};
    x_step = is_cfa3 ? mod3(3'(x_base_q) + 3'(PPC)) : {1'b0, x_base_q[0] ^ 1'(PPC)};

    vsync_d       = in_vsync;
    hsync_d       = in_hsync;
    mode_d        = mode_q;
    y_phase_d     = y_phase_q;
    x_base_d      = x_base_q;
    line_active_d = line_active_q;
`ifdef VIN_COLORMIXER_DITHER_EN
    row_d = row_q;
    col_d = col_q;
`endif
    if (vs_rise) begin
      mode_d        = mode_e'(cfg_mode);
      y_phase_d     = 2'd0;
      x_base_d      = 2'd0;
      line_active_d = 1'b0;
`ifdef VIN_COLORMIXER_DITHER_EN
      row_d = 2'd0;
      col_d = 2'd0;
`endif
    end else if (hs_rise && line_active_q) begin
      y_phase_d     = y_inc;
      x_base_d      = is_cfa3 ? y_inc : 2'd0;
      line_active_d = 1'b0;
`ifdef VIN_COLORMIXER_DITHER_EN
      row_d = row_q + 2'd1;
      col_d = 2'd0;
`endif
    end else if (in_valid) begin
      line_active_d = 1'b1;
      x_base_d      = x_step;
`ifdef VIN_COLORMIXER_DITHER_EN
      col_d = col_q + 2'(PPC);
`endif
    end
  end

  // Stage 1 captures selected samples; stage 2 reduces to OUT_BPP and holds when idle.
  always_comb begin
    s1_valid_d  = in_valid;
    s1_pix_d    = in_valid ? sel_c : s1_pix_q;
    out_valid_d = s1_valid_q;
    out_color_d = out_color_q;
    sat         = 8'd0;
`ifdef VIN_COLORMIXER_DITHER_EN
    s1_row_d = in_valid ? row_q : s1_row_q;
    s1_col_d = in_valid ? col_q : s1_col_q;
    pcol     = 2'd0;
    thr      = 8'd0;
    dsum     = 9'd0;
`endif
    if (s1_valid_q) begin
      for (int k = 0; k < int'(PPC); k++) begin
`ifdef VIN_COLORMIXER_DITHER_EN
        pcol = s1_col_q + 2'(k);
        thr  = 8'(BAYER4[{s1_row_q, pcol}]) >> (OUT_BPP - 4);
        dsum = 9'(s1_pix_q[k]) + 9'(thr);
        sat  = dsum[8] ? 8'hFF : dsum[7:0];
`else
        sat  = s1_pix_q[k];
`endif
        out_color_d[(PPC-1-k)*OUT_BPP +: OUT_BPP] = OUT_BPP'(sat >> SHIFT);
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      vsync_q       <= 1'b0;
      hsync_q       <= 1'b0;
      mode_q        <= MODE_MONO;
      y_phase_q     <= 2'd0;
      x_base_q      <= 2'd0;
      line_active_q <= 1'b0;
      s1_pix_q      <= '0;
      s1_valid_q    <= 1'b0;
      out_color_q   <= '0;
      out_valid_q   <= 1'b0;
`ifdef VIN_COLORMIXER_DITHER_EN
      row_q    <= 2'd0;
      col_q    <= 2'd0;
      s1_row_q <= 2'd0;
      s1_col_q <= 2'd0;
`endif
    end else begin
      vsync_q       <= vsync_d;
      hsync_q       <= hsync_d;
      mode_q        <= mode_d;
      y_phase_q     <= y_phase_d;
      x_base_q      <= x_base_d;
      line_active_q <= line_active_d;
      s1_pix_q      <= s1_pix_d;
      s1_valid_q    <= s1_valid_d;
      out_color_q   <= out_color_d;
      out_valid_q   <= out_valid_d;
`ifdef VIN_COLORMIXER_DITHER_EN
      row_q    <= row_d;
      col_q    <= col_d;
      s1_row_q <= s1_row_d;
      s1_col_q <= s1_col_d;
`endif
    end
  end

  assign out_color = out_color_q;
  assign out_valid = out_valid_q;
  assign out_mode  = mode_q;

endmodule

// File: tb/tb_vin_colormixer_mc.sv
`timescale 1ns/1ps
// Scoreboard bench for vin_colormixer_mc: a PPC=2/8bpp instance and a PPC=4/4bpp instance.
module tb_vin_colormixer_mc;

  typedef struct {
    logic [15:0] color;
    logic [1:0]  mode;
    string       tag;
  } exp_t;

`ifdef VIN_COLORMIXER_DITHER_EN
  // Luma 8 at 4bpp: output is 1 where the Bayer threshold is >= 8.
  localparam logic [15:0] T_EVEN = 16'h0101;
  localparam logic [15:0] T_ODD  = 16'h1010;
`else
  localparam logic [15:0] T_EVEN = 16'h0000;
  localparam logic [15:0] T_ODD  = 16'h0000;
`endif

  logic        clk = 1'b0;
  logic        rstn;
  logic [1:0]  cfg_mode;
  logic        in_vsync, in_hsync;
  logic [47:0] in_color_a;
  logic [95:0] in_color_b;
  logic        in_valid_a, in_valid_b;
  logic [15:0] out_color_a, out_color_b;
  logic        out_valid_a, out_valid_b;
  logic [1:0]  out_mode_a, out_mode_b;

  exp_t qa[$];
  exp_t qb[$];
  exp_t ea, eb;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  vin_colormixer_mc #(.PPC(2), .OUT_BPP(8)) dut_a (
    .clk(clk), .rstn(rstn), .cfg_mode(cfg_mode), .in_vsync(in_vsync), .in_hsync(in_hsync),
    .in_color(in_color_a), .in_valid(in_valid_a),
    .out_color(out_color_a), .out_valid(out_valid_a), .out_mode(out_mode_a)
  );

  vin_colormixer_mc #(.PPC(4), .OUT_BPP(4)) dut_b (
    .clk(clk), .rstn(rstn), .cfg_mode(cfg_mode), .in_vsync(in_vsync), .in_hsync(in_hsync),
    .in_color(in_color_b), .in_valid(in_valid_b),
    .out_color(out_color_b), .out_valid(out_valid_b), .out_mode(out_mode_b)
  );

  function automatic logic [47:0] px2(input logic [7:0] r0, g0, b0, r1, g1, b1);
    return {r0, g0, b0, r1, g1, b1};
  endfunction

  function automatic logic [95:0] px4(input logic [7:0] r, g, b);
    return {4{r, g, b}};
  endfunction

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic cyc(input logic va, input logic [47:0] pa, input logic vb, input logic [95:0] pb,
                     input logic hs, input logic vs);
    @(negedge clk);
    in_valid_a = va; in_color_a = pa;
    in_valid_b = vb; in_color_b = pb;
    in_hsync = hs; in_vsync = vs;
  endtask

  task automatic idle(input int n);
    repeat (n) cyc(1'b0, '0, 1'b0, '0, 1'b0, 1'b0);
  endtask

  task automatic hs_pulse();
    cyc(1'b0, '0, 1'b0, '0, 1'b1, 1'b0);
    idle(2);
  endtask

  task automatic vs_pulse(input logic [1:0] m);
    cfg_mode = m;
    cyc(1'b0, '0, 1'b0, '0, 1'b0, 1'b1);
    idle(2);
  endtask

  task automatic beat_a(input logic [47:0] p, input logic [15:0] e, input logic [1:0] m,
                        input logic hs, input string t);
    cyc(1'b1, p, 1'b0, '0, hs, 1'b0);
    qa.push_back('{color: e, mode: m, tag: t});
  endtask

  task automatic beat_b(input logic [95:0] p, input logic [15:0] e, input logic [1:0] m,
                        input string t);
    cyc(1'b0, '0, 1'b1, p, 1'b0, 1'b0);
    qb.push_back('{color: e, mode: m, tag: t});
  endtask

  // Reset lands mid-burst: in-flight beats are dropped, outputs clear at once.
  task automatic reset_pulse();
    @(negedge clk);
    rstn = 1'b0;
    in_valid_a = 1'b1;
    qa.delete();
    qb.delete();
    #1;
    chk("rst_mid_valid", 16'(out_valid_a), 16'd0);
    chk("rst_mid_color", out_color_a, 16'd0);
    chk("rst_mid_mode", 16'(out_mode_a), 16'd0);
    @(negedge clk);
    rstn = 1'b1;
    in_valid_a = 1'b0;
  endtask

  always @(posedge clk) begin
    #1;
    if (rstn && out_valid_a) begin
      checks++;
      if (qa.size() == 0) begin
        errors++;
        $display("FAIL a_unexpected: got color=%h with nothing pending", out_color_a);
      end else begin
        ea = qa.pop_front();
        if ({out_mode_a, out_color_a} !== {ea.mode, ea.color}) begin
          errors++;
          $display("FAIL %s: got mode=%0d color=%h, expected mode=%0d color=%h",
                   ea.tag, out_mode_a, out_color_a, ea.mode, ea.color);
        end
      end
    end
    if (rstn && out_valid_b) begin
      checks++;
      if (qb.size() == 0) begin
        errors++;
        $display("FAIL b_unexpected: got color=%h with nothing pending", out_color_b);
      end else begin
        eb = qb.pop_front();
        if ({out_mode_b, out_color_b} !== {eb.mode, eb.color}) begin
          errors++;
          $display("FAIL %s: got mode=%0d color=%h, expected mode=%0d color=%h",
                   eb.tag, out_mode_b, out_color_b, eb.mode, eb.color);
        end
      end
    end
  end

  initial begin
    #50000;
    $display("FAIL watchdog: simulation did not complete, %0d checks, %0d errors", checks, errors);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [47:0] pc, pw;
    logic [95:0] pb_cfa, pb_l8, pb_l250;
    pc      = px2(8'd10, 8'd20, 8'd30, 8'd10, 8'd20, 8'd30);
    pw      = px2(8'd200, 8'd100, 8'd50, 8'd200, 8'd100, 8'd50);
    pb_cfa  = px4(8'h10, 8'h20, 8'h30);
    pb_l8   = px4(8'd8, 8'd8, 8'd8);
    pb_l250 = px4(8'd250, 8'd250, 8'd250);

    rstn = 1'b0; cfg_mode = 2'd0; in_vsync = 1'b0; in_hsync = 1'b0;
    in_valid_a = 1'b0; in_valid_b = 1'b0; in_color_a = '0; in_color_b = '0;
    repeat (3) @(negedge clk);
    chk("reset_valid_a", 16'(out_valid_a), 16'd0);
    chk("reset_color_a", out_color_a, 16'd0);
    chk("reset_mode_a", 16'(out_mode_a), 16'd0);
    chk("reset_valid_b", 16'(out_valid_b), 16'd0);
    chk("reset_color_b", out_color_b, 16'd0);
    rstn = 1'b1;

    // MONO luma, latency and hold
    vs_pulse(2'd0);
    chk("mono_mode", 16'(out_mode_a), 16'd0);
    beat_a(px2(8'd255, 8'd255, 8'd255, 8'd255, 8'd0, 8'd0), 16'hFF4C, 2'd0, 1'b0, "mono_white_red");
    idle(1);
    chk("lat_1cyc_valid", 16'(out_valid_a), 16'd0);
    idle(1);
    chk("lat_2cyc_valid", 16'(out_valid_a), 16'd1);
    chk("lat_2cyc_color", out_color_a, 16'hFF4C);
    idle(1);
    chk("valid_drop", 16'(out_valid_a), 16'd0);
    idle(2);
    chk("hold_color", out_color_a, 16'hFF4C);

    // CFA3: three lines, blank hsync between line 0 and 1
    vs_pulse(2'd1);
    chk("cfa3_mode", 16'(out_mode_a), 16'd1);
    hs_pulse();
    beat_a(pc, 16'h0A14, 2'd1, 1'b0, "cfa_l0_b0");
    beat_a(pc, 16'h1E0A, 2'd1, 1'b0, "cfa_l0_b1");
    beat_a(pc, 16'h141E, 2'd1, 1'b0, "cfa_l0_b2");
    idle(2); hs_pulse(); hs_pulse();
    beat_a(pc, 16'h141E, 2'd1, 1'b0, "cfa_l1_b0");
    beat_a(pc, 16'h0A14, 2'd1, 1'b0, "cfa_l1_b1");
    beat_a(pc, 16'h1E0A, 2'd1, 1'b0, "cfa_l1_b2");
    idle(2); hs_pulse();
    beat_a(pc, 16'h1E0A, 2'd1, 1'b0, "cfa_l2_b0");
    beat_a(pc, 16'h141E, 2'd1, 1'b0, "cfa_l2_b1");
    beat_a(pc, 16'h0A14, 2'd1, 1'b0, "cfa_l2_b2");
    idle(3);

    // cfg_mode change mid-frame is deferred to the next vsync
    vs_pulse(2'd0);
    beat_a(pw, 16'h7C7C, 2'd0, 1'b0, "mono_pre_cfg");
    cfg_mode = 2'd2;
    idle(2); hs_pulse();
    beat_a(pw, 16'h7C7C, 2'd0, 1'b0, "mono_after_cfg");
    idle(3);
    chk("mode_held", 16'(out_mode_a), 16'd0);

    // RGBW, including hsync coincident with the last beat of row 0
    vs_pulse(2'd2);
    chk("rgbw_mode", 16'(out_mode_a), 16'd2);
    hs_pulse();
    beat_a(pw, 16'hC864, 2'd2, 1'b0, "rgbw_r0_b0");
    beat_a(pw, 16'hC864, 2'd2, 1'b1, "rgbw_r0_hs");
    beat_a(pw, 16'h3232, 2'd2, 1'b0, "rgbw_r1_b0");
    beat_a(pw, 16'h3232, 2'd2, 1'b0, "rgbw_r1_b1");
    idle(2); hs_pulse();
    beat_a(pw, 16'hC864, 2'd2, 1'b0, "rgbw_r2_b0");
    idle(3);

    // Reset during a burst, then a fresh frame starts at phase 0
    vs_pulse(2'd1);
    beat_a(pc, 16'h0A14, 2'd1, 1'b0, "pre_rst_b0");
    beat_a(pc, 16'h1E0A, 2'd1, 1'b0, "pre_rst_b1");
    reset_pulse();
    idle(2);
    vs_pulse(2'd1);
    beat_a(pc, 16'h0A14, 2'd1, 1'b0, "post_rst_b0");
    idle(3);

    // 4bpp instance: CFA3 with PPC=4 phase step, then dither tile and saturation
    vs_pulse(2'd1);
    beat_b(pb_cfa, 16'h1231, 2'd1, "b_cfa_b0");
    beat_b(pb_cfa, 16'h2312, 2'd1, "b_cfa_b1");
    idle(3);
    vs_pulse(2'd0);
    hs_pulse();
    beat_b(pb_l8, T_EVEN, 2'd0, "b_row0");
    beat_b(pb_l250, 16'hFFFF, 2'd0, "b_sat");
    idle(2); hs_pulse(); hs_pulse();
    beat_b(pb_l8, T_ODD, 2'd0, "b_row1");
    idle(2); hs_pulse();
    beat_b(pb_l8, T_EVEN, 2'd0, "b_row2");
    idle(2); hs_pulse();
    beat_b(pb_l8, T_ODD, 2'd0, "b_row3");
    idle(2); hs_pulse();
    beat_b(pb_l8, T_EVEN, 2'd0, "b_row4_wrap");
    idle(5);

    chk("drain_a", 16'(qa.size()), 16'd0);
    chk("drain_b", 16'(qb.size()), 16'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
